// File: rtl/split_constraint_seq.sv
// split_constraint_seq
//   Streams NUM_VARS variable beats (one per cycle over valid/ready), accumulates
//   them into a saturating sum and evaluates one selectable constraint on the
//   final sum. The verdict x is returned with a one-cycle done pulse.
//
//   Parameters
//     NUM_VARS  number of beats per evaluation (>= 1)
//     VAR_W     beat width
//     SUM_W     accumulator width (saturates at 2^SUM_W-1)
//     MODE      0: x = 1, 1: x = (sum <= LIMIT), 2: x = (sum >= LIMIT)
//     LIMIT     bound used by MODE 1/2
//
//   Ports
//     clk       clock, rising edge
//     rst       synchronous active-high reset
//     start     begin an evaluation (only honoured in IDLE)
//     in_valid  beat valid
//     in_ready  block accepts a beat this cycle (high only in COLLECT)
//     in_data   beat value
//     in_last   sequencer marks the final beat
//     busy      high in COLLECT and EVAL
//     done      one-cycle pulse, x is valid
//     x         verdict, held until the next accepted start
//     err       sticky protocol error, cleared by the next accepted start
//
//   Handshake: a beat transfers on a rising edge where in_valid and in_ready
//   are both high. in_ready depends only on state, never on in_valid, so the
//   sender may hold in_valid high for any number of cycles.
module split_constraint_seq #(
    parameter int             NUM_VARS = 150,
    parameter int             VAR_W    = 16,
    parameter int             SUM_W    = 24,
    parameter int             MODE     = 0,
    parameter logic [SUM_W-1:0] LIMIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAR_W-1:0] in_data,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             err
);

    localparam int CNT_W = $clog2(NUM_VARS + 1);
    localparam int EXT_W = ((SUM_W > VAR_W) ? SUM_W : VAR_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VARS - 1);
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2
    } state_t;

    // state is kept as a named enum signal so checkers can bind to it.
    state_t           state;
    state_t           state_next;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             final_beat;
    logic             err_set;
    logic             verdict;
    logic [EXT_W-1:0] sum_ext;
    logic [SUM_W-1:0] sum_sat;

    // Widen before adding so the carry out is visible; clamp instead of wrap.
    always_comb begin
        sum_ext = EXT_W'(sum) + EXT_W'(in_data);
        if (sum_ext > EXT_W'(SUM_MAX)) begin
            sum_sat = SUM_MAX;
        end else begin
            sum_sat = sum_ext[SUM_W-1:0];
        end
    end

    // Verdict is computed in EVAL from the already-registered final sum and
    // error flag; an error always forces a negative verdict.
    always_comb begin
        verdict = 1'b1;
        case (MODE)
            1:       verdict = (sum <= LIMIT);
            2:       verdict = (sum >= LIMIT);
            default: verdict = 1'b1;
        endcase
        if (err) begin
            verdict = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        final_beat = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    if (cnt == LAST_CNT) begin
                        // Count reached: a missing in_last is a protocol error.
                        final_beat = 1'b1;
                        err_set    = ~in_last;
                    end else if (in_last) begin
                        // Sequencer terminated early.
                        final_beat = 1'b1;
                        err_set    = 1'b1;
                    end
                end
                if (final_beat) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            x     <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sum <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                        x   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        sum <= sum_sat;
                        cnt <= cnt + CNT_W'(1);
                        if (err_set) begin
                            err <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    done <= 1'b1;
                    x    <= verdict;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_split_constraint_seq.sv
// Bench for split_constraint_seq: three instances with different parameter
// sets share one clock and reset; each has its own stimulus signals.
//   u0: NUM_VARS=150, MODE 0
//   u1: NUM_VARS=4,   MODE 1, LIMIT=1000, SUM_W=24
//   u2: NUM_VARS=4,   MODE 2, LIMIT=255,  SUM_W=8
module tb_split_constraint_seq;

    localparam int     NV   [3] = '{150, 4, 4};
    localparam int     MD   [3] = '{0, 1, 2};
    localparam longint LIM  [3] = '{0, 1000, 255};
    localparam longint SMAX [3] = '{64'd16777215, 64'd16777215, 64'd255};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start    [3];
    logic        in_valid [3];
    logic [15:0] in_data  [3];
    logic        in_last  [3];
    logic        in_ready [3];
    logic        busy     [3];
    logic        done     [3];
    logic        x        [3];
    logic        err      [3];

    split_constraint_seq #(.NUM_VARS(150), .VAR_W(16), .SUM_W(24), .MODE(0), .LIMIT(24'd0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .busy(busy[0]), .done(done[0]), .x(x[0]), .err(err[0]));
    split_constraint_seq #(.NUM_VARS(4), .VAR_W(16), .SUM_W(24), .MODE(1), .LIMIT(24'd1000)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .busy(busy[1]), .done(done[1]), .x(x[1]), .err(err[1]));
    split_constraint_seq #(.NUM_VARS(4), .VAR_W(16), .SUM_W(8), .MODE(2), .LIMIT(8'd255)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .busy(busy[2]), .done(done[2]), .x(x[2]), .err(err[2]));

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt [3] = '{0, 0, 0};
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks a transaction as "collecting / evaluating / idle" with the true
    // (unbounded) running sum and beat count; saturation and the constraint
    // are applied once, on the final sum.
    bit     m_col  [3];
    bit     m_eval [3];
    bit     m_err  [3];
    bit     m_x    [3];
    bit     m_done [3];
    longint m_sum  [3];
    int     m_n    [3];

    function automatic bit verdict(input int i, input longint s);
        longint v;
        v = (s > SMAX[i]) ? SMAX[i] : s;
        case (MD[i])
            0:       return 1'b1;
            1:       return v <= LIM[i];
            default: return v >= LIM[i];
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_col[i]  <= 1'b0;
                m_eval[i] <= 1'b0;
                m_err[i]  <= 1'b0;
                m_x[i]    <= 1'b0;
                m_done[i] <= 1'b0;
                m_sum[i]  <= 0;
                m_n[i]    <= 0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_eval[i]) begin
                    m_eval[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_x[i]    <= !m_err[i] && verdict(i, m_sum[i]);
                end else if (m_col[i]) begin
                    if (in_valid[i]) begin
                        m_sum[i] <= m_sum[i] + longint'(in_data[i]);
                        m_n[i]   <= m_n[i] + 1;
                        if ((m_n[i] + 1 == NV[i]) || in_last[i]) begin
                            m_col[i]  <= 1'b0;
                            m_eval[i] <= 1'b1;
                            m_err[i]  <= (m_n[i] + 1 != NV[i]) || !in_last[i];
                        end
                    end
                end else if (start[i]) begin
                    m_col[i] <= 1'b1;
                    m_sum[i] <= 0;
                    m_n[i]   <= 0;
                    m_err[i] <= 1'b0;
                    m_x[i]   <= 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("in_ready[%0d]", i), int'(in_ready[i]), int'(m_col[i]));
                check($sformatf("busy[%0d]", i), int'(busy[i]), int'(m_col[i] | m_eval[i]));
                check($sformatf("done[%0d]", i), int'(done[i]), int'(m_done[i]));
                check($sformatf("x[%0d]", i), int'(x[i]), int'(m_x[i]));
                check($sformatf("err[%0d]", i), int'(err[i]), int'(m_err[i]));
                if (done[i] === 1'b1) begin
                    done_cnt[i]++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int vec [150];

    task automatic drive(input int i, input bit st, input bit v, input logic [15:0] d, input bit l);
        @(negedge clk);
        start[i]    = st;
        in_valid[i] = v;
        in_data[i]  = d;
        in_last[i]  = l;
    endtask

    task automatic idle(input int i, input int n);
        repeat (n) drive(i, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    // Start, then nb beats from vec; in_last on beat last_pos (0 = never).
    // With gaps set, up to three idle cycles precede each beat, and those idle
    // cycles may carry a stray start pulse and junk data.
    task automatic run_txn(input int i, input int nb, input int last_pos, input bit gaps);
        drive(i, 1'b1, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3))
                    drive(i, 1'($urandom_range(0, 1)), 1'b0, 16'hdead, 1'b0);
            end
            drive(i, 1'b0, 1'b1, 16'(vec[k]), (k + 1) == last_pos);
        end
        idle(i, 5);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        vec[0] = a; vec[1] = b; vec[2] = c; vec[3] = d;
    endtask

    // ---------------- directed sequence ----------------
    int dc0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy[%0d]", i), int'(busy[i]), 0);
            check($sformatf("reset_ready[%0d]", i), int'(in_ready[i]), 0);
            check($sformatf("reset_done[%0d]", i), int'(done[i]), 0);
            check($sformatf("reset_x[%0d]", i), int'(x[i]), 0);
            check($sformatf("reset_err[%0d]", i), int'(err[i]), 0);
        end
        chk_en = 1'b1;
        rst    = 1'b0;

        // MODE 0, 150 random beats, in_last on the 150th.
        for (int k = 0; k < 150; k++) vec[k] = $urandom_range(0, 65535);
        dc0 = done_cnt[0];
        run_txn(0, 150, 150, 1'b0);
        check("m0_done_once", done_cnt[0] - dc0, 1);
        check("m0_x", int'(x[0]), 1);
        check("m0_err", int'(err[0]), 0);

        // MODE 1, sum exactly at the limit, then one above.
        set4(100, 200, 300, 400);
        dc0 = done_cnt[1];
        run_txn(1, 4, 4, 1'b0);
        check("m1_eq_limit_x", int'(x[1]), 1);
        check("m1_eq_limit_done", done_cnt[1] - dc0, 1);
        set4(100, 200, 300, 401);
        run_txn(1, 4, 4, 1'b0);
        check("m1_over_limit_x", int'(x[1]), 0);
        check("m1_over_limit_err", int'(err[1]), 0);

        // MODE 2, 8-bit accumulator: 800 must clamp to 255, not wrap to 32.
        set4(200, 200, 200, 200);
        run_txn(2, 4, 4, 1'b0);
        check("m2_sat_x", int'(x[2]), 1);
        check("m2_sat_err", int'(err[2]), 0);

        // Early in_last on beat 2.
        set4(10, 20, 30, 40);
        dc0 = done_cnt[1];
        run_txn(1, 2, 2, 1'b0);
        check("early_last_err", int'(err[1]), 1);
        check("early_last_x", int'(x[1]), 0);
        check("early_last_done", done_cnt[1] - dc0, 1);

        // Next start clears err; then beat 4 arrives without in_last.
        drive(1, 1'b1, 1'b0, 16'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 16'd0, 1'b0);
        check("err_cleared_by_start", int'(err[1]), 0);
        for (int k = 0; k < 4; k++) drive(1, 1'b0, 1'b1, 16'(vec[k]), 1'b0);
        idle(1, 5);
        check("missing_last_err", int'(err[1]), 1);
        check("missing_last_x", int'(x[1]), 0);

        // Random valid gaps with stray start pulses inside COLLECT.
        set4(10, 20, 30, 40);
        dc0 = done_cnt[1];
        run_txn(1, 4, 4, 1'b1);
        check("gaps_done_once", done_cnt[1] - dc0, 1);
        check("gaps_x", int'(x[1]), 1);
        check("gaps_err", int'(err[1]), 0);
        set4(50, 60, 70, 75);
        run_txn(2, 4, 4, 1'b1);
        check("gaps_m2_x", int'(x[2]), 1);
        for (int k = 0; k < 150; k++) vec[k] = $urandom_range(0, 65535);
        dc0 = done_cnt[0];
        run_txn(0, 150, 150, 1'b1);
        check("gaps_m0_done_once", done_cnt[0] - dc0, 1);

        // Reset after 2 of 4 beats aborts without a done pulse.
        set4(900, 900, 900, 900);
        dc0 = done_cnt[1];
        drive(1, 1'b1, 1'b0, 16'd0, 1'b0);
        drive(1, 1'b0, 1'b1, 16'(vec[0]), 1'b0);
        drive(1, 1'b0, 1'b1, 16'(vec[1]), 1'b0);
        drive(1, 1'b0, 1'b0, 16'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy[1]), 0);
        check("abort_ready", int'(in_ready[1]), 0);
        idle(1, 4);
        check("abort_no_done", done_cnt[1] - dc0, 0);
        set4(300, 300, 300, 100);
        run_txn(1, 4, 4, 1'b0);
        check("after_abort_x", int'(x[1]), 1);
        check("after_abort_done", done_cnt[1] - dc0, 1);

        idle(0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
